// File: rtl/uart_peripheral_pkg.sv
// UART peripheral shared definitions: register map, STATUS bit
// positions and the engine state encoding used by both TX and RX.
package uart_peripheral_pkg;
    typedef enum logic [1:0] {
        UART_TXDATA = 2'd0,
        UART_RXDATA = 2'd1,
        UART_STATUS = 2'd2,
        UART_CTRL   = 2'd3
    } uart_reg_e;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_VALID = 2;
    localparam int ST_OVR      = 3;
    localparam int ST_FERR     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;
endpackage

// File: rtl/uart_peripheral_if.sv
// CPU data-bus slave port of the UART window.
// The MEM-stage bus decoder is the master.
interface uart_peripheral_if;
    logic        Sel;
    logic [1:0]  Offset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    modport master (
        output Sel, Offset, MemRead, MemWrite, Write_data,
        input  Read_data
    );
    modport slave (
        input  Sel, Offset, MemRead, MemWrite, Write_data,
        output Read_data
    );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO, power-of-two depth; push when full and pop
// when empty are ignored. Head is the oldest entry.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full    = count_q == AW1'(DEPTH);
    assign empty   = count_q == '0;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + AW1'(do_push) - AW1'(do_pop);
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART with TX FIFO and interrupt.
// `UART_RX_FIFO_EN selects an RX FIFO instead of a holding register.
module uart_peripheral
    import uart_peripheral_pkg::*;
#(
    parameter int BAUD_DIV = 5208,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    uart_peripheral_if.slave bus,
    input  logic             uart_rx,
    output logic             uart_tx,
    output logic             IRQ
);
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    uart_reg_e   reg_sel;
    logic        wr_en, rd_en;
    logic        tx_push, tx_pop, tx_full, tx_fifo_empty, tx_empty;
    logic [7:0]  tx_head;
    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [7:0]  tx_sr_q, tx_sr_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        txd_q, txd_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [7:0]  rx_sr_q, rx_sr_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_push, rx_pop, rx_full, rx_valid;
    logic [7:0]  rx_head;
    logic        set_ovr, set_ferr;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
    logic [31:0] status;
    logic        unused;

    assign reg_sel  = uart_reg_e'(bus.Offset);
    assign wr_en    = bus.Sel & bus.MemWrite;
    assign rd_en    = bus.Sel & bus.MemRead;
    assign tx_push  = wr_en && reg_sel == UART_TXDATA && !tx_full;
    assign rx_pop   = rd_en && reg_sel == UART_RXDATA && rx_valid;
    assign tx_empty = tx_fifo_empty && tx_state_q == IDLE;
    assign uart_tx  = txd_q;
    assign IRQ      = irq_q;
    assign unused   = ^{bus.Write_data[31:8], 16'(RX_DEPTH)};

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
        .din(bus.Write_data[7:0]), .full(tx_full),
        .empty(tx_fifo_empty), .head(tx_head)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q - 16'd1;
        tx_sr_d    = tx_sr_q;
        tx_bit_d   = tx_bit_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            IDLE: tx_cnt_d = tx_cnt_q;
            START: if (tx_cnt_q == '0) begin
                tx_cnt_d   = BAUD_LAST;
                tx_bit_d   = '0;
                txd_d      = tx_sr_q[0];
                tx_sr_d    = {1'b0, tx_sr_q[7:1]};
                tx_state_d = DATA;
            end
            DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = BAUD_LAST;
                if (tx_bit_q == 3'd7) begin
                    txd_d      = 1'b1;
                    tx_state_d = STOP;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    txd_d    = tx_sr_q[0];
                    tx_sr_d  = {1'b0, tx_sr_q[7:1]};
                end
            end
            STOP: if (tx_cnt_q == '0) tx_state_d = IDLE;
        endcase
        // Start (or chain) a frame straight from the FIFO head
        if (tx_state_d == IDLE && !tx_fifo_empty) begin
            tx_pop     = 1'b1;
            tx_sr_d    = tx_head;
            tx_cnt_d   = BAUD_LAST;
            txd_d      = 1'b0;
            tx_state_d = START;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q - 16'd1;
        rx_sr_d    = rx_sr_q;
        rx_bit_d   = rx_bit_q;
        rx_push    = 1'b0;
        set_ovr    = 1'b0;
        set_ferr   = 1'b0;
        unique case (rx_state_q)
            IDLE: begin
                rx_cnt_d = HALF_LAST;
                if (rx_prev_q && !rx_s2_q) rx_state_d = START;
            end
            START: if (rx_cnt_q == '0) begin
                rx_cnt_d   = BAUD_LAST;
                rx_bit_d   = '0;
                rx_state_d = rx_s2_q ? IDLE : DATA;
            end
            DATA: if (rx_cnt_q == '0) begin
                rx_cnt_d = BAUD_LAST;
                rx_sr_d  = {rx_s2_q, rx_sr_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = STOP;
            end
            STOP: if (rx_cnt_q == '0) begin
                rx_state_d = IDLE;
                if (!rx_s2_q)     set_ferr = 1'b1;
                else if (rx_full) set_ovr  = 1'b1;
                else              rx_push  = 1'b1;
            end
        endcase
    end

`ifdef UART_RX_FIFO_EN
    logic rx_empty;

    uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop),
        .din(rx_sr_q), .full(rx_full),
        .empty(rx_empty), .head(rx_head)
    );
    assign rx_valid = !rx_empty;
`else
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_hold_q, rx_hold_d;

    always_comb begin
        rx_valid_d = rx_valid_q & ~rx_pop;
        rx_hold_d  = rx_hold_q;
        if (rx_push) begin
            rx_valid_d = 1'b1;
            rx_hold_d  = rx_sr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q <= 1'b0;
            rx_hold_q  <= '0;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_hold_q  <= rx_hold_d;
        end
    end
    assign rx_valid = rx_valid_q;
    assign rx_full  = rx_valid_q;
    assign rx_head  = rx_hold_q;
`endif

    always_comb begin
        ctrl_d = ctrl_q;
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        if (wr_en && reg_sel == UART_CTRL) ctrl_d = bus.Write_data[1:0];
        if (wr_en && reg_sel == UART_STATUS) begin
            if (bus.Write_data[ST_OVR])  ovr_d  = 1'b0;
            if (bus.Write_data[ST_FERR]) ferr_d = 1'b0;
        end
        // A set event in the same cycle as a clear write wins
        if (set_ovr)  ovr_d  = 1'b1;
        if (set_ferr) ferr_d = 1'b1;
        irq_d = (ctrl_q[0] & tx_empty) | (ctrl_q[1] & rx_valid);
    end

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_VALID] = rx_valid;
        status[ST_OVR]      = ovr_q;
        status[ST_FERR]     = ferr_q;
        bus.Read_data       = '0;
        if (rd_en) begin
            unique case (reg_sel)
                UART_RXDATA: bus.Read_data = rx_valid ? {24'd0, rx_head} : '0;
                UART_STATUS: bus.Read_data = status;
                UART_CTRL:   bus.Read_data = {30'd0, ctrl_q};
                default:     bus.Read_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_sr_q    <= '0;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_sr_q    <= '0;
            rx_bit_q   <= '0;
            ctrl_q     <= '0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_sr_q    <= tx_sr_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sr_q    <= rx_sr_d;
            rx_bit_q   <= rx_bit_d;
            ctrl_q     <= ctrl_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            irq_q      <= irq_d;
        end
    end
endmodule

// File: tb/tb_uart_peripheral.sv
// Self-checking bench for uart_peripheral (BAUD_DIV=4, TX_DEPTH=4,
// holding-register RX store).
module tb_uart_peripheral;
    localparam int BAUD = 4;
    localparam int TXD  = 4;
    localparam logic [1:0] R_TX = 2'd0, R_RX = 2'd1, R_ST = 2'd2, R_CTRL = 2'd3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx, IRQ;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    logic [7:0] mon_q[$];
    int         mon_start[$];
    logic       mon_stop[$];

    uart_peripheral_if bus();

    uart_peripheral #(.BAUD_DIV(BAUD), .TX_DEPTH(TXD), .RX_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .IRQ(IRQ)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  off;
        logic        wr;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_access(input logic [1:0] off, input logic wr, input logic [31:0] wd,
                              output logic [31:0] rdv);
        @(negedge clk);
        bus.Sel = 1'b1;
        bus.Offset = off;
        bus.MemWrite = wr;
        bus.MemRead = !wr;
        bus.Write_data = wd;
        #1 rdv = bus.Read_data;
        @(posedge clk);
        #1;
        bus.Sel = 1'b0;
        bus.MemWrite = 1'b0;
        bus.MemRead = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = f[i];
            repeat (BAUD - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic wait_frames(input string name, input int n, input int limit);
        int t;
        t = 0;
        while (mon_q.size() < n && t < limit) begin
            @(negedge clk);
            t++;
        end
        idle(60);
        check(name, mon_q.size(), n);
    endtask

    // Serial decoder on uart_tx: mid-bit sampling from the start edge
    initial begin
        logic [7:0] b;
        int sc;
        forever begin
            @(negedge clk);
            if (uart_tx === 1'b0 && !reset) begin
                sc = cyc;
                repeat (BAUD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (BAUD) @(negedge clk);
                mon_stop.push_back(uart_tx);
                mon_start.push_back(sc);
                mon_q.push_back(b);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  f;
        logic        e;
        logic [7:0]  b, b2;
        logic [7:0]  exp_q[$];
        logic        rv_h[$];
        logic        irq_h[$];
        int          k, idx;
        vec_t        vt[8];

        vt[0] = '{R_ST,   1'b0, 32'h0,   1'b1, 32'h2, 1'b0};
        vt[1] = '{R_RX,   1'b0, 32'h0,   1'b1, 32'h0, 1'b0};
        vt[2] = '{R_CTRL, 1'b1, 32'h1,   1'b0, 32'h0, 1'b1};
        vt[3] = '{R_CTRL, 1'b1, 32'h2,   1'b0, 32'h0, 1'b0};
        vt[4] = '{R_CTRL, 1'b1, 32'hFC,  1'b0, 32'h0, 1'b0};
        vt[5] = '{R_CTRL, 1'b1, 32'h101, 1'b0, 32'h0, 1'b1};
        vt[6] = '{R_ST,   1'b1, 32'h18,  1'b0, 32'h0, 1'b1};
        vt[7] = '{R_CTRL, 1'b1, 32'h0,   1'b0, 32'h0, 1'b0};

        bus.Sel = 1'b0;
        bus.Offset = 2'd0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        bus.Write_data = '0;
        idle(3);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_irq", IRQ, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            bus_access(vt[i].off, vt[i].wr, vt[i].wd, rd);
            if (vt[i].chk_rd) check($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
            idle(2);
            check($sformatf("vec%0d_irq", i), IRQ, vt[i].exp_irq);
        end
        bus_access(R_ST, 1'b0, 0, rd);
        check("vec_status_after_clear", rd, 32'h2);

        // Single byte, exact waveform
        mon_q.delete();
        bus_access(R_TX, 1'b1, 32'hA5, rd);
        f = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 42; j++) begin
            @(negedge clk);
            e = (j == 0 || j >= 41) ? 1'b1 : f[(j - 1) / BAUD];
            check($sformatf("t1_tx_c%0d", j), uart_tx, e);
        end
        idle(6);
        bus_access(R_ST, 1'b0, 0, rd);
        check("t1_tx_empty", rd, 32'h2);

        // Burst of six writes: FIFO fills, sixth dropped
        mon_q.delete();
        mon_start.delete();
        mon_stop.delete();
        for (int i = 1; i <= 6; i++) bus_access(R_TX, 1'b1, i, rd);
        bus_access(R_ST, 1'b0, 0, rd);
        check("t2_status_full", rd, 32'h1);
        wait_frames("t2_frame_count", 5, 400);
        for (int i = 0; i < mon_q.size(); i++) begin
            check($sformatf("t2_byte%0d", i), mon_q[i], i + 1);
            check($sformatf("t2_stop%0d", i), mon_stop[i], 1);
            if (i > 0)
                check($sformatf("t2_gap%0d", i), mon_start[i] - mon_start[i - 1], 10 * BAUD);
        end

        // Receive one byte
        send_frame(8'h3C, 1'b1);
        idle(4);
        bus_access(R_ST, 1'b0, 0, rd);
        check("t3_status_valid", rd, 32'h6);
        bus_access(R_RX, 1'b0, 0, rd);
        check("t3_rxdata", rd, 32'h3C);
        bus_access(R_ST, 1'b0, 0, rd);
        check("t3_status_popped", rd, 32'h2);
        bus_access(R_RX, 1'b0, 0, rd);
        check("t3_rxdata_empty", rd, 32'h0);

        // Overrun
        send_frame(8'hC3, 1'b1);
        send_frame(8'h99, 1'b1);
        idle(4);
        bus_access(R_ST, 1'b0, 0, rd);
        check("t4_status_ovr", rd, 32'hE);
        bus_access(R_ST, 1'b1, 32'h8, rd);
        bus_access(R_ST, 1'b0, 0, rd);
        check("t4_ovr_cleared", rd, 32'h6);
        bus_access(R_RX, 1'b0, 0, rd);
        check("t4_first_kept", rd, 32'hC3);

        // Framing error with a byte already held, then a glitch
        send_frame(8'h81, 1'b1);
        idle(4);
        send_frame(8'h42, 1'b0);
        idle(4);
        bus_access(R_ST, 1'b0, 0, rd);
        check("t5_status_ferr", rd, 32'h16);
        bus_access(R_ST, 1'b1, 32'h10, rd);
        bus_access(R_ST, 1'b0, 0, rd);
        check("t5_ferr_cleared", rd, 32'h6);
        bus_access(R_RX, 1'b0, 0, rd);
        check("t5_byte_kept", rd, 32'h81);
        @(negedge clk);
        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(20);
        bus_access(R_ST, 1'b0, 0, rd);
        check("t5_glitch_ignored", rd, 32'h2);

        // Random RX bytes against the received-byte model
        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            idle(4);
            bus_access(R_RX, 1'b0, 0, rd);
            check($sformatf("rnd_rx%0d", n), rd, {24'd0, b});
            bus_access(R_ST, 1'b0, 0, rd);
            check($sformatf("rnd_rx_st%0d", n), rd, 32'h2);
        end

        // Random TX bursts: at most TXD+1 bytes are accepted back to back
        for (int n = 0; n < 4; n++) begin
            k = $urandom_range(1, 6);
            mon_q.delete();
            mon_stop.delete();
            mon_start.delete();
            exp_q.delete();
            for (int i = 0; i < k; i++) begin
                b2 = 8'($urandom);
                if (i < TXD + 1) exp_q.push_back(b2);
                bus_access(R_TX, 1'b1, {24'd0, b2}, rd);
            end
            wait_frames($sformatf("rnd_tx_count%0d", n), exp_q.size(), 400);
            for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
                check($sformatf("rnd_tx%0d_b%0d", n, i), mon_q[i], exp_q[i]);
        end

        // RX interrupt latency
        bus_access(R_CTRL, 1'b1, 32'h2, rd);
        @(negedge clk);
        bus.Sel = 1'b1;
        bus.Offset = R_ST;
        bus.MemRead = 1'b1;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                for (int t = 0; t < 60; t++) begin
                    @(negedge clk);
                    #1;
                    rv_h.push_back(bus.Read_data[2]);
                    irq_h.push_back(IRQ);
                end
            end
        join
        bus.Sel = 1'b0;
        bus.MemRead = 1'b0;
        idx = -1;
        for (int i = 0; i < rv_h.size(); i++)
            if (rv_h[i] && idx < 0) idx = i;
        check("t6_rx_valid_seen", (idx >= 0 && idx < 59), 1);
        if (idx >= 0 && idx < 59) begin
            check("t6_irq_before", irq_h[idx], 0);
            check("t6_irq_after", irq_h[idx + 1], 1);
        end
        bus_access(R_RX, 1'b0, 0, rd);
        check("t6_rxdata", rd, 32'h5A);
        @(negedge clk);
        check("t6_irq_hold", IRQ, 1);
        @(negedge clk);
        check("t6_irq_clear", IRQ, 0);

        // Reset in the middle of a transmission
        send_frame(8'h77, 1'b1);
        idle(4);
        bus_access(R_TX, 1'b1, 32'h55, rd);
        idle(12);
        check("t6_irq_pre_reset", IRQ, 1);
        check("t6_tx_mid_frame", uart_tx, 0);
        reset = 1'b1;
        @(negedge clk);
        check("t6_reset_tx", uart_tx, 1);
        check("t6_reset_irq", IRQ, 0);
        reset = 1'b0;
        bus_access(R_ST, 1'b0, 0, rd);
        check("t6_reset_status", rd, 32'h2);
        idle(60);
        check("t6_tx_idle", uart_tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
